// File: rtl/pulse_period_meter_pkg.sv
// Shared types and helpers for the pulse period meter.
// Holds the FSM state encoding and the ceiling-log2 width helper.
package pulse_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_e;

    // Bits needed to hold values 0 .. value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pulse_period_meter_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector.
// rise is a one-cycle flag per low-to-high transition of async_in.
module sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic rise_q, rise_d;

    // Shift the input through the synchronizer and flag a new high level.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        rise_d  = sync2_q & ~sync3_q;
    end

    // Register the synchronizer chain and edge flag.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the period of pulse_in in clk_in cycles.
// Flags timeout when pulses stop and locked when periods are stable.
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_PERIOD = 65535,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    localparam int MW = clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_PERIOD);
    localparam logic [WIDTH:0]   TOLV = (WIDTH+1)'(TOL);
    localparam logic [MW-1:0]    LCV  = MW'(LOCK_COUNT);

    logic rise;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [MW-1:0]    match_q, match_d;

    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]        mag;
    logic                  close;

    sync_edge u_sync_edge (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_in(pulse_in),
        .rise    (rise)
    );

    // Next-state logic for the period counter, lock history and flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        pv_d        = 1'b0;
        timeout_d   = timeout_q;
        locked_d    = locked_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;

        diff  = $signed({1'b0, cnt_q}) - $signed({1'b0, prev_q});
        mag   = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        close = (mag <= TOLV);

        unique case (state_q)
            IDLE, TIMEOUT: begin
                if (rise) begin
                    state_d     = MEASURE;
                    cnt_d       = WIDTH'(1);
                    timeout_d   = 1'b0;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                    match_d     = '0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d    = cnt_q;
                    pv_d        = 1'b1;
                    cnt_d       = WIDTH'(1);
                    prev_d      = cnt_q;
                    have_prev_d = 1'b1;
                    if (have_prev_q) begin
                        if (close) begin
                            if (match_q != LCV) begin
                                match_d = match_q + MW'(1);
                            end
                            locked_d = (match_d == LCV);
                        end else begin
                            match_d  = '0;
                            locked_d = 1'b0;
                        end
                    end
                end else if (cnt_q == MAXV) begin
                    state_d     = TIMEOUT;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                    match_d     = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register FSM state and all outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            pv_q        <= 1'b0;
            timeout_q   <= 1'b0;
            locked_q    <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            match_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
            timeout_q   <= timeout_d;
            locked_q    <= locked_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter.
// Stimulus predicts strobe/timeout events; a monitor checks them.
module tb_pulse_period_meter;

    localparam int W    = 16;
    localparam int MAXP = 20;
    localparam int TOL  = 1;
    localparam int LC   = 4;
    localparam int LAT  = 3;

    logic         clk_in   = 1'b0;
    logic         reset    = 1'b1;
    logic         pulse_in = 1'b0;
    logic [W-1:0] period;
    logic         period_valid;
    logic         timeout;
    logic         locked;

    always #5 clk_in = ~clk_in;

    pulse_period_meter #(
        .WIDTH     (W),
        .MAX_PERIOD(MAXP),
        .TOL       (TOL),
        .LOCK_COUNT(LC)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .period      (period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .locked      (locked)
    );

    // kind: 0 = period strobe, 1 = timeout rises, 2 = timeout clears
    typedef struct {
        int kind;
        int t;
        int period;
        bit locked;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  t        = 0;

    bit  meas = 0;
    bit  tmo  = 0;
    bit  lvl  = 0;
    bit  have_prev = 0;
    int  last_t = 0;
    int  prev_p = 0;
    int  match = 0;
    int  last_period = 0;
    int  last_edge_t = -100;
    bit  to_prev = 0;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic void push(input int kind, input int tt,
                                 input int p, input bit l);
        ev_t e;
        e.kind = kind;
        e.t = tt;
        e.period = p;
        e.locked = l;
        q.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // One cycle of stimulus plus the reference model's view of it.
    task automatic step(input bit p);
        bit edge_seen;
        bit lk;
        int d;
        @(negedge clk_in);
        t++;
        reset = 1'b0;
        pulse_in = p;
        edge_seen = p & ~lvl;
        lvl = p;
        if (edge_seen) begin
            last_edge_t = t;
            if (!meas) begin
                if (tmo) push(2, t + LAT, last_period, 1'b0);
                tmo = 0;
                meas = 1;
                last_t = t;
                have_prev = 0;
                match = 0;
            end else begin
                d = t - last_t;
                if (have_prev) begin
                    if (iabs(d - prev_p) <= TOL)
                        match = (match < LC) ? match + 1 : LC;
                    else
                        match = 0;
                end
                lk = (match == LC);
                prev_p = d;
                have_prev = 1;
                last_period = d;
                last_t = t;
                push(0, t + LAT, d, lk);
            end
        end else if (meas && (t - last_t == MAXP)) begin
            meas = 0;
            tmo = 1;
            have_prev = 0;
            match = 0;
            push(1, t + LAT, last_period, 1'b0);
        end
    endtask

    task automatic pulse_gap(input int gap);
        repeat (gap - 1) step(1'b0);
        step(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_valid"}, int'(period_valid), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_locked"}, int'(locked), 0);
    endtask

    // Reset for n cycles, kept clear of edges still inside the synchronizer.
    task automatic do_reset(input int n);
        int r;
        while (t - last_edge_t < 5 || lvl) step(1'b0);
        @(negedge clk_in);
        t++;
        reset = 1'b1;
        pulse_in = 1'b0;
        lvl = 0;
        r = t;
        while (q.size() > 0 && q[$].t >= r) void'(q.pop_back());
        meas = 0;
        tmo = 0;
        have_prev = 0;
        match = 0;
        last_period = 0;
        repeat (n - 1) begin
            @(negedge clk_in);
            t++;
        end
        @(negedge clk_in);
        t++;
        check_zero("reset");
        reset = 1'b0;
    endtask

    // Monitor: pop and compare whenever the DUT shows an event.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (reset) begin
                to_prev = timeout;
            end else begin
                int k;
                ev_t e;
                k = -1;
                if (period_valid) k = 0;
                else if (timeout && !to_prev) k = 1;
                else if (!timeout && to_prev) k = 2;
                to_prev = timeout;
                if (k >= 0) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: kind=%0d t=%0d period=%0d",
                                 k, t, period);
                    end else begin
                        e = q.pop_front();
                        if (e.kind != k || e.t != t || e.period != int'(period)
                            || e.locked != locked) begin
                            n_fail++;
                            $display("FAIL event: got kind=%0d t=%0d period=%0d locked=%0d expected kind=%0d t=%0d period=%0d locked=%0d",
                                     k, t, period, locked,
                                     e.kind, e.t, e.period, e.locked);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
        $fatal(1);
    end

    initial begin
        repeat (3) begin
            @(negedge clk_in);
            t++;
        end
        check_zero("init");

        repeat (9) pulse_gap(6);
        idle(25);
        repeat (4) pulse_gap(6);

        repeat (5) begin
            pulse_gap(6);
            pulse_gap(9);
        end

        pulse_gap(20);
        pulse_gap(20);
        pulse_gap(21);
        pulse_gap(5);
        pulse_gap(5);

        pulse_gap(6);
        repeat (30) step(1'b1);
        idle(3);
        pulse_gap(4);
        pulse_gap(4);

        repeat (3) pulse_gap(7);
        idle(5);
        do_reset(1);
        pulse_gap(4);
        pulse_gap(8);
        pulse_gap(8);

        for (int i = 0; i < 120; i++) begin
            int base;
            int n;
            int sel;
            base = int'($urandom_range(3, 17));
            n = int'($urandom_range(2, 7));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) do_reset(int'($urandom_range(1, 3)));
            else if (sel == 1) pulse_gap(int'($urandom_range(18, 24)));
            for (int j = 0; j < n; j++) begin
                pulse_gap(base + int'($urandom_range(0, 2)));
            end
        end

        idle(30);
        check("pending_events", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
